// File: rtl/endme_pkg.sv
// EnDMe shared types: opcodes, ALU ops, accumulator sources.
// Also holds the datapath and instruction widths.
package endme_pkg;

  localparam int W  = 8;
  localparam int IW = 9;

  localparam logic [W-1:0] ACC_TRUE = 8'd1;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SLL = 4'h5,
    OP_SRL = 4'h6,
    OP_SLT = 4'h7,
    OP_MOV = 4'h8,
    OP_STR = 4'h9,
    OP_LDM = 4'hA,
    OP_STM = 4'hB,
    OP_BR  = 4'hC,
    OP_JMP = 4'hD,
    OP_NPE = 4'hE,
    OP_NPF = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2,
    SRC_ALU = 2'd3
  } acc_src_e;

endpackage

// File: rtl/endme_alu.sv
// EnDMe 8-bit ALU, purely combinational.
// Shifts by 8 or more give zero; SLT is unsigned.
module endme_alu
  import endme_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] y
);

  logic big_sh;

  assign big_sh = |b[W-1:3];

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = big_sh ? '0 : a << b[2:0];
      ALU_SRL: y = big_sh ? '0 : a >> b[2:0];
      ALU_SLT: y = {{(W-1){1'b0}}, a < b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/endme_exec_core.sv
// EnDMe execute core: decoder, ALU and accumulator.
// Every instruction completes in a single clock.
module endme_exec_core
  import endme_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic [IW-1:0] instr,
  input  logic [W-1:0]  reg_data,
  input  logic [W-1:0]  mem_data,
  output logic [W-1:0]  acc_out,
  output logic [W-1:0]  alu_out,
  output logic [3:0]    reg_addr,
  output logic          reg_we,
  output logic          mem_we,
  output logic          br_ctrl,
  output logic          jmp_ctrl,
  output logic          acc_is_one
);

  logic         typ;
  opcode_e      op;
  alu_op_e      alu_op;
  logic [W-1:0] acc;
  logic [W-1:0] acc_d;
  acc_src_e     acc_sel;
  logic         acc_we;
  logic         dec_reg_we;
  logic         dec_mem_we;
  logic         dec_br;
  logic         dec_jmp;

  assign typ    = instr[8];
  assign op     = opcode_e'(instr[7:4]);
  assign alu_op = alu_op_e'(instr[6:4]);

  endme_alu u_alu (
    .a  (acc),
    .b  (reg_data),
    .op (alu_op),
    .y  (alu_out)
  );

  // Unknown typ lands in default, so no enable fires.
  always_comb begin
    acc_we     = 1'b0;
    acc_sel    = SRC_ALU;
    dec_reg_we = 1'b0;
    dec_mem_we = 1'b0;
    dec_br     = 1'b0;
    dec_jmp    = 1'b0;
    unique case (1'b1)
      (typ == 1'b1): begin
        acc_we  = 1'b1;
        acc_sel = SRC_IMM;
      end
      (typ == 1'b0 && instr[7] == 1'b0): begin
        acc_we  = 1'b1;
        acc_sel = SRC_ALU;
      end
      (typ == 1'b0 && instr[7] == 1'b1): begin
        unique case (op)
          OP_MOV: begin
            acc_we  = 1'b1;
            acc_sel = SRC_REG;
          end
          OP_LDM: begin
            acc_we  = 1'b1;
            acc_sel = SRC_MEM;
          end
          OP_STR:  dec_reg_we = 1'b1;
          OP_STM:  dec_mem_we = 1'b1;
          OP_BR:   dec_br     = 1'b1;
          OP_JMP:  dec_jmp    = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d = alu_out;
    unique case (acc_sel)
      SRC_IMM: acc_d = instr[7:0];
      SRC_REG: acc_d = reg_data;
      SRC_MEM: acc_d = mem_data;
      SRC_ALU: acc_d = alu_out;
      default: acc_d = alu_out;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc <= '0;
    end else if (acc_we) begin
      acc <= acc_d;
    end
  end

  assign acc_out    = acc;
  assign acc_is_one = (acc == ACC_TRUE);
  assign reg_addr   = instr[3:0];
  assign reg_we     = dec_reg_we & RESET;
  assign mem_we     = dec_mem_we & RESET;
  assign br_ctrl    = dec_br     & RESET;
  assign jmp_ctrl   = dec_jmp    & RESET;

endmodule

// File: tb/tb_endme_exec_core.sv
// Directed vector bench for the EnDMe execute core.
// Vector table plus hand-written reset sequences.
module tb_endme_exec_core;

  logic       CLK;
  logic       RESET;
  logic [8:0] instr;
  logic [7:0] reg_data;
  logic [7:0] mem_data;
  logic [7:0] acc_out;
  logic [7:0] alu_out;
  logic [3:0] reg_addr;
  logic       reg_we;
  logic       mem_we;
  logic       br_ctrl;
  logic       jmp_ctrl;
  logic       acc_is_one;

  int n_vec;
  int n_bad;

  endme_exec_core dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .instr      (instr),
    .reg_data   (reg_data),
    .mem_data   (mem_data),
    .acc_out    (acc_out),
    .alu_out    (alu_out),
    .reg_addr   (reg_addr),
    .reg_we     (reg_we),
    .mem_we     (mem_we),
    .br_ctrl    (br_ctrl),
    .jmp_ctrl   (jmp_ctrl),
    .acc_is_one (acc_is_one)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [8:0] ins;
    logic [7:0] rd;
    logic [7:0] md;
    logic [3:0] en;
    logic [7:0] acc;
  } vec_t;

  vec_t vt[$];

  function automatic logic [8:0] li(input logic [7:0] imm);
    return {1'b1, imm};
  endfunction

  function automatic logic [8:0] rr(
    input logic [3:0] op,
    input logic [3:0] rs
  );
    return {1'b0, op, rs};
  endfunction

  task automatic chk(
    input string      nm,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] ens();
    return {reg_we, mem_we, br_ctrl, jmp_ctrl};
  endfunction

  task automatic add(
    input string      nm,
    input logic [8:0] ins,
    input logic [7:0] rd,
    input logic [7:0] md,
    input logic [3:0] en,
    input logic [7:0] acc
  );
    vec_t v;
    v.name = nm;
    v.ins  = ins;
    v.rd   = rd;
    v.md   = md;
    v.en   = en;
    v.acc  = acc;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    instr    = v.ins;
    reg_data = v.rd;
    mem_data = v.md;
    #1;
    chk({v.name, "_en"}, {4'h0, ens()}, {4'h0, v.en});
    chk({v.name, "_addr"}, {4'h0, reg_addr},
        {4'h0, v.ins[3:0]});
    @(posedge CLK);
    #1;
    chk({v.name, "_acc"}, acc_out, v.acc);
    chk({v.name, "_one"}, {7'h0, acc_is_one},
        {7'h0, v.acc == 8'd1});
  endtask

  logic [8:0] rst_ins [4];

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    RESET    = 1'b0;
    instr    = rr(4'h9, 4'h4);
    reg_data = 8'h00;
    mem_data = 8'h00;

    // enable bits: {reg_we, mem_we, br, jmp}
    add("li_ff",   li(8'hFF),        8'h00, 8'h00, 4'b0000, 8'hFF);
    add("add",     rr(4'h0, 4'h2),   8'h02, 8'h00, 4'b0000, 8'h01);
    add("li_3",    li(8'h03),        8'h00, 8'h00, 4'b0000, 8'h03);
    add("sub",     rr(4'h1, 4'h1),   8'h05, 8'h00, 4'b0000, 8'hFE);
    add("slt_t",   rr(4'h7, 4'h1),   8'hFF, 8'h00, 4'b0000, 8'h01);
    add("li_5",    li(8'h05),        8'h00, 8'h00, 4'b0000, 8'h05);
    add("slt_f",   rr(4'h7, 4'h1),   8'h03, 8'h00, 4'b0000, 8'h00);
    add("li_81",   li(8'h81),        8'h00, 8'h00, 4'b0000, 8'h81);
    add("sll",     rr(4'h5, 4'h1),   8'h01, 8'h00, 4'b0000, 8'h02);
    add("srl9",    rr(4'h6, 4'h1),   8'h09, 8'h00, 4'b0000, 8'h00);
    add("li_f0",   li(8'hF0),        8'h00, 8'h00, 4'b0000, 8'hF0);
    add("srl4",    rr(4'h6, 4'h1),   8'h04, 8'h00, 4'b0000, 8'h0F);
    add("sll8",    rr(4'h5, 4'h1),   8'h08, 8'h00, 4'b0000, 8'h00);
    add("li_a5",   li(8'hA5),        8'h00, 8'h00, 4'b0000, 8'hA5);
    add("str",     rr(4'h9, 4'h4),   8'h11, 8'h22, 4'b1000, 8'hA5);
    add("stm",     rr(4'hB, 4'h3),   8'h40, 8'h22, 4'b0100, 8'hA5);
    add("ldm",     rr(4'hA, 4'h3),   8'h40, 8'h3C, 4'b0000, 8'h3C);
    add("and",     rr(4'h2, 4'h6),   8'h0F, 8'h00, 4'b0000, 8'h0C);
    add("or",      rr(4'h3, 4'h6),   8'hF0, 8'h00, 4'b0000, 8'hFC);
    add("xor",     rr(4'h4, 4'h6),   8'hFF, 8'h00, 4'b0000, 8'h03);
    add("mov",     rr(4'h8, 4'h7),   8'h01, 8'h00, 4'b0000, 8'h01);
    add("br",      rr(4'hC, 4'h2),   8'h10, 8'h00, 4'b0010, 8'h01);
    add("jmp",     rr(4'hD, 4'h2),   8'h20, 8'h00, 4'b0001, 8'h01);
    add("nop_e",   rr(4'hE, 4'h0),   8'h77, 8'h66, 4'b0000, 8'h01);
    add("nop_f",   rr(4'hF, 4'hF),   8'h77, 8'h66, 4'b0000, 8'h01);
    add("li_5a",   li(8'h5A),        8'h00, 8'h00, 4'b0000, 8'h5A);

    // power-on reset: acc clear, enables gated even for STR
    #2;
    chk("por_acc", acc_out, 8'h00);
    chk("por_en", {4'h0, ens()}, 4'h0);
    @(posedge CLK);
    #1;
    chk("por_hold", acc_out, 8'h00);
    RESET = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // asynchronous reset mid-cycle with acc=5A
    rst_ins[0] = rr(4'h9, 4'h4);
    rst_ins[1] = rr(4'hB, 4'h1);
    rst_ins[2] = rr(4'hC, 4'h1);
    rst_ins[3] = rr(4'hD, 4'h1);
    instr = rst_ins[0];
    #2;
    chk("pre_rst_acc", acc_out, 8'h5A);
    RESET = 1'b0;
    #1;
    chk("rst_acc", acc_out, 8'h00);
    for (int k = 0; k < 4; k++) begin
      instr = rst_ins[k];
      #1;
      chk("rst_en", {4'h0, ens()}, 4'h0);
    end

    // release mid-cycle; update lands on next edge
    instr = li(8'h77);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rel_acc", acc_out, 8'h00);
    @(posedge CLK);
    #1;
    chk("rel_upd", acc_out, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
